imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/imm_decode.sv | 75 +++++++
 rtl/imm_gen_pipe.sv | 83 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: immediate format enum, base opcodes and
// compressed-instruction quadrant/funct3 codes.
package riscv_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_C    = 3'd6
    } imm_type_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;

    localparam logic [2:0] C_F3_ADDI = 3'b000;
    localparam logic [2:0] C_F3_LI   = 3'b010;
    localparam logic [2:0] C_F3_LW   = 3'b010;
    localparam logic [2:0] C_F3_SW   = 3'b110;
    localparam logic [2:0] C_F3_J    = 3'b101;
    localparam logic [2:0] C_F3_BEQZ = 3'b110;
    localparam logic [2:0] C_F3_BNEZ = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for 32-bit RISC-V formats; compressed
// encodings are decoded only when IMMGEN_RVC_EN is defined.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type
);

    logic signed [31:0] imm32;
    imm_type_e          typ;

    always_comb begin
        imm32 = '0;
        typ   = IMM_NONE;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    typ   = IMM_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
                OPC_STORE: begin
                    typ   = IMM_S;
                    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                OPC_BRANCH: begin
                    typ   = IMM_B;
                    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    typ   = IMM_U;
                    imm32 = {inst[31:12], 12'b0};
                end
                OPC_JAL: begin
                    typ   = IMM_J;
                    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                default: ;
            endcase
        end
`ifdef IMMGEN_RVC_EN
        else begin
            case ({inst[1:0], inst[15:13]})
                {RVC_Q1, C_F3_ADDI}, {RVC_Q1, C_F3_LI}: begin
                    typ   = IMM_C;
                    imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
                end
                {RVC_Q0, C_F3_LW}, {RVC_Q0, C_F3_SW}: begin
                    typ   = IMM_C;
                    imm32 = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
                end
                {RVC_Q1, C_F3_J}: begin
                    typ   = IMM_C;
                    imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6],
                             inst[7], inst[2], inst[11], inst[5:3], 1'b0};
                end
                {RVC_Q1, C_F3_BEQZ}, {RVC_Q1, C_F3_BNEZ}: begin
                    typ   = IMM_C;
                    imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2],
                             inst[11:10], inst[4:3], 1'b0};
                end
                default: ;
            endcase
        end
`endif
    end

    // Every format is at most 32 bits wide, so widening is a plain sign extension.
    assign imm      = XLEN'(imm32);
    assign imm_type = typ;

endmodule

// File: rtl/imm_gen_pipe.sv
// One-cycle immediate generator with a registered 2-entry (output + skid) buffer.
// Compressed decode is enabled by defining IMMGEN_RVC_EN.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    beat_t           in_beat;
    beat_t           out_q;
    beat_t           skid_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic            in_ready_q;
    logic            accept;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst     (in_inst),
        .imm      (dec_imm),
        .imm_type (dec_type)
    );

    assign in_beat = '{imm: dec_imm, typ: dec_type, tag: in_tag};
    assign accept  = in_valid && in_ready_q;

    // in_ready is low whenever the skid entry is occupied, so a refill from
    // skid and a new accept never happen on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (!out_valid_q || out_ready) begin
            in_ready_q <= 1'b1;
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_q <= in_beat;
                end
            end
        end else if (accept) begin
            skid_q       <= in_beat;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_q.imm;
    assign out_type  = out_q.typ;
    assign out_tag   = out_q.tag;

endmodule
